// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the CPU
// instruction-fetch port (if_*) and the CPU data port (d_*). One access is in
// flight at a time. The data port has priority, but fetch is forced to win
// after STARVE_MAX consecutive data grants while it waits.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_req/if_addr                  fetch request (read only)
//   if_gnt/if_rvalid/if_rdata       fetch accept pulse, response pulse, held data
//   d_req/d_wen/d_addr/d_wdata      data request (read or write)
//   d_gnt/d_rvalid/d_rdata          data accept pulse, response/write-ack pulse, held data
//   mem_en/mem_wen/mem_addr/mem_wdata/mem_rdata   memory side
//   busy                            FSM not idle
// All outputs are registered.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // 4 bits covers MEM_LAT up to 8 and STARVE_MAX up to 15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state, state_d;
  logic              owner, owner_d;       // 1 = data port owns the transaction
  logic [CNT_W-1:0]  starve, starve_d;
  logic [CNT_W-1:0]  lat, lat_d;
  logic              d_win;

  logic              mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_d, d_rdata_d;
  logic              if_gnt_d, d_gnt_d, mem_en_d, if_rvalid_d, d_rvalid_d, busy_d;

  // Next-state, arbitration and next values of the registered outputs.
  always_comb begin
    state_d     = state;
    owner_d     = owner;
    starve_d    = starve;
    lat_d       = lat;
    d_win       = 1'b0;
    mem_wen_d   = mem_wen;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;

    unique case (state)
      S_IDLE: begin
        if (if_req || d_req) begin
          // Data wins unless fetch has waited through STARVE_MAX data grants.
          d_win      = (d_req && (starve < CNT_W'(STARVE_MAX))) || !if_req;
          owner_d    = d_win;
          mem_addr_d = d_win ? d_addr : if_addr;
          mem_wen_d  = d_win && d_wen;
          if (d_win) begin
            mem_wdata_d = d_wdata;
          end
          if (d_win && if_req) begin
            starve_d = (starve == CNT_W'(STARVE_MAX)) ? starve : starve + CNT_W'(1);
          end else begin
            starve_d = '0;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        lat_d   = CNT_W'(MEM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Counter reads 1 exactly MEM_LAT cycles after ISSUE: read data is valid now.
        if (lat == CNT_W'(1)) begin
          lat_d   = '0;
          state_d = S_RESP;
          if (!mem_wen) begin
            if (owner) d_rdata_d  = mem_rdata;
            else       if_rdata_d = mem_rdata;
          end
        end else begin
          lat_d = lat - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    mem_en_d    = (state_d == S_ISSUE);
    if_gnt_d    = (state_d == S_ISSUE) && !owner_d;
    d_gnt_d     = (state_d == S_ISSUE) &&  owner_d;
    if_rvalid_d = (state_d == S_RESP)  && !owner_d;
    d_rvalid_d  = (state_d == S_RESP)  &&  owner_d;
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      starve    <= '0;
      lat       <= '0;
      mem_en    <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      starve    <= starve_d;
      lat       <= lat_d;
      mem_en    <= mem_en_d;
      mem_wen   <= mem_wen_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_gnt    <= if_gnt_d;
      d_gnt     <= d_gnt_d;
      if_rvalid <= if_rvalid_d;
      d_rvalid  <= d_rvalid_d;
      if_rdata  <= if_rdata_d;
      d_rdata   <= d_rdata_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// request traffic. A reference model predicts each transaction at
// arbitration time and queues it; a separate monitor checks the DUT against
// the queue head every cycle. A memory responder returns read data only in
// the cycle ISSUE+MEM_LAT and 0xBAD otherwise.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MEM_LAT    = 3;
  localparam int unsigned STARVE_MAX = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req = 1'b0;
  logic              d_wen = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en, mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          port;   // 1 = data port
    logic [31:0] addr;
    bit          wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gcyc;   // grant / mem_en cycle
    int          rcyc;   // rvalid cycle
  } txn_t;

  txn_t exp_q[$];

  logic [31:0] ref_mem [64];
  logic [31:0] dev_mem [64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"},
          64'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_wen, busy}), 64'(0));
    check({name, "_data"}, {if_rdata | d_rdata, mem_addr | mem_wdata}, 64'(0));
  endtask

  // Memory responder and reference model (arbitration by rule, queue of predictions).
  int          starve = 0;
  int          next_free = 0;
  int          due_cyc = -1;
  logic [31:0] due_data = '0;
  bit          dw;
  txn_t        t;
  initial forever begin
    @(negedge clk);
    if (rst_n && mem_en) begin
      due_data = dev_mem[mem_addr[5:0]];
      due_cyc  = cyc + int'(MEM_LAT);
      if (mem_wen) dev_mem[mem_addr[5:0]] = mem_wdata;
    end
    mem_rdata = (due_cyc == cyc) ? due_data : 32'h0000_0BAD;

    if (!rst_n) begin
      exp_q.delete();
      starve    = 0;
      next_free = 0;
      due_cyc   = -1;
    end else if (cyc >= next_free && (if_req || d_req)) begin
      dw      = (d_req && starve < int'(STARVE_MAX)) || !if_req;
      t.port  = dw;
      t.addr  = dw ? d_addr : if_addr;
      t.wen   = dw && d_wen;
      t.wdata = d_wdata;
      if (t.wen) begin
        ref_mem[t.addr[5:0]] = t.wdata;
        t.rdata = '0;
      end else begin
        t.rdata = ref_mem[t.addr[5:0]];
      end
      t.gcyc = cyc + 1;
      t.rcyc = cyc + 2 + int'(MEM_LAT);
      exp_q.push_back(t);
      if (dw && if_req) starve = (starve < int'(STARVE_MAX)) ? starve + 1 : starve;
      else              starve = 0;
      next_free = cyc + int'(MEM_LAT) + 3;
    end
  end

  // Monitor: compares DUT outputs with the head of the prediction queue.
  logic [31:0] exp_ir = '0;
  logic [31:0] exp_dr = '0;
  txn_t        h;
  bit          have, e_busy, e_resp;
  logic [4:0]  e_ctrl, a_ctrl;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_ir = '0;
      exp_dr = '0;
      check_all_zero("reset");
    end else begin
      have = (exp_q.size() > 0);
      if (have) h = exp_q[0];
      e_busy = have && cyc >= h.gcyc && cyc <= h.rcyc;
      e_resp = have && cyc == h.rcyc;
      e_ctrl = {have && cyc == h.gcyc && !h.port,
                have && cyc == h.gcyc &&  h.port,
                have && cyc == h.gcyc,
                e_resp && !h.port,
                e_resp &&  h.port};
      a_ctrl = {if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid};
      if (a_ctrl != 5'b0 || e_ctrl != 5'b0) check("gnt_memen_rvalid", 64'(a_ctrl), 64'(e_ctrl));
      check("busy", 64'(busy), 64'(e_busy));
      if (e_busy) begin
        check("mem_addr", 64'(mem_addr), 64'(h.addr));
        check("mem_wen", 64'(mem_wen), 64'(h.wen));
        if (h.wen) check("mem_wdata", 64'(mem_wdata), 64'(h.wdata));
      end
      if (e_resp && !h.wen) begin
        if (h.port) exp_dr = h.rdata;
        else        exp_ir = h.rdata;
      end
      check("rdata_if_d", {if_rdata, d_rdata}, {exp_ir, exp_dr});
      if (e_resp) void'(exp_q.pop_front());
    end
  end

  task automatic new_if();
    if_req  = 1'b1;
    if_addr = $urandom();
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_wen   = 1'($urandom_range(0, 1));
    d_addr  = $urandom();
    d_wdata = $urandom();
  endtask

  // One cycle of requester behaviour. mode 0: no new requests; 1: re-request
  // immediately after every grant; 2: random traffic with occasional withdrawal.
  task automatic step(input int mode);
    @(posedge clk);
    #1;
    if (if_req && if_gnt) if_req = 1'b0;
    if (d_req && d_gnt)   d_req  = 1'b0;
    if (mode == 1) begin
      if (!if_req) new_if();
      if (!d_req)  new_d();
    end else if (mode == 2) begin
      if (if_req && !if_gnt && $urandom_range(0, 49) == 0) if_req = 1'b0;
      else if (!if_req && $urandom_range(0, 2) != 0) new_if();
      if (d_req && !d_gnt && $urandom_range(0, 49) == 0) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 2) != 0) new_d();
    end
  endtask

  task automatic reset_mid_wait();
    int n = 0;
    do begin
      step(2);
      n++;
    end while (!(if_gnt || d_gnt) && n < 100);
    if (n >= 100) check("grant_before_reset_timeout", 64'(0), 64'(1));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    if_req = 1'b0;
    d_req  = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    if_req  = 1'b1;
    if_addr = 32'h0000_0044;
    repeat (8) step(0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom();
      dev_mem[i] = ref_mem[i];
    end
    ref_mem[16] = 32'hDEAD_BEEF;
    dev_mem[16] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) step(0);

    // Single fetch.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    repeat (8) step(0);

    // Data write.
    @(posedge clk); #1;
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h0000_0005; d_wdata = 32'h0000_1234;
    repeat (8) step(0);

    // Simultaneous fetch and data read.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    d_req  = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_0020;
    repeat (16) step(0);

    // Both ports saturated: starvation guard.
    repeat (60) step(1);
    repeat (20) step(0);

    // Random traffic with a reset in the middle of a read wait.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) reset_mid_wait();
      else           step(2);
    end

    repeat (40) step(0);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the CPU instruction-fetch port and the CPU data (lw/sw) port.
- Lets a unified instruction/data memory replace the separate instruction and data memories.
- Arbitrates one access at a time, sequences the memory's fixed read latency, and returns a registered response pulse to the winning requester.
- Fixed data-over-fetch priority, with a starvation guard for fetch.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MEM_LAT, 1, cycles from the mem_en cycle to mem_rdata valid; legal range 1 to 8.
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced to win; legal range 1 to 15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- if_req  input  1  fetch request
- if_addr  input  ADDR_W  fetch address
- if_gnt  output  1  fetch request accepted (1-cycle pulse)
- if_rvalid  output  1  fetch data valid (1-cycle pulse)
- if_rdata  output  DATA_W  fetch read data
- d_req  input  1  data request
- d_wen  input  1  1 = write, 0 = read
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  write data
- d_gnt  output  1  data request accepted (1-cycle pulse)
- d_rvalid  output  1  data read data valid, or write acknowledge (1-cycle pulse)
- d_rdata  output  DATA_W  data read data
- mem_en  output  1  memory access strobe (1-cycle pulse)
- mem_wen  output  1  memory write enable, qualified by mem_en
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data
- busy  output  1  high when the FSM is not in IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; starvation counter 0; latency counter 0. Reset asserted mid-transaction aborts it immediately: mem_en and all pulses drop asynchronously, no response is delivered, and the memory write may or may not have landed.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Samples if_req and d_req each cycle.
  - If either is high, it picks a winner, latches owner, addr, wen and wdata, and goes to ISSUE.
  - If neither is high, it stays in IDLE.
- Arbitration rule:
  - d wins if d_req=1 and starve_cnt<STARVE_MAX.
  - Otherwise if wins if if_req=1.
  - Otherwise d wins.
- Starvation counter (starve_cnt):
  - At each arbitration, increments when d wins while if_req=1, saturating at STARVE_MAX.
  - Clears when if wins, or when if_req=0 at arbitration.
- ISSUE (exactly 1 cycle):
  - Owner's gnt=1, mem_en=1.
  - mem_wen = latched wen; the fetch port always reads.
  - mem_addr and mem_wdata are driven from registers, stable from ISSUE through the end of RESP.
  - Latency counter loads MEM_LAT.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter reads 1, mem_rdata is sampled (this is the cycle ISSUE+MEM_LAT).
  - Then go to RESP.
- RESP (exactly 1 cycle):
  - Owner's rvalid=1.
  - For reads, owner's rdata = captured mem_rdata.
  - For writes, rdata holds its previous value; rvalid serves as the write acknowledge.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle T -> gnt and mem_en at T+1 -> rvalid at T+2+MEM_LAT. Minimum spacing between grants is MEM_LAT+3 cycles.
- if_rdata and d_rdata are independent holding registers; each updates only on its own read response.
- Handshake:
  - A requester holds req, addr, wen and wdata stable until it sees gnt.
  - Requests arriving in non-IDLE states wait; they are not lost and not queued.
  - A req that drops before gnt is legal and is simply not served.
- Simultaneous events: if_req and d_req rising in the same IDLE cycle follow the arbitration rule. gnt for the two ports is never high in the same cycle; rvalid for the two ports is never high in the same cycle.
- No combinational path from any input to any output.

Test Plan:
1. Single fetch, MEM_LAT=1: if_req=1, if_addr=0x10 at cycle 0; memory returns 0xDEADBEEF in cycle 2 -> if_gnt=1, mem_en=1, mem_addr=0x10, mem_wen=0 in cycle 1; if_rvalid=1 with if_rdata=0xDEADBEEF in cycle 3; busy=1 for cycles 1-3.
2. Simultaneous requests, starve_cnt=0: if_req=d_req=1 (d read, addr 0x20) -> d_gnt in cycle 1 only; if_gnt at cycle 5, i.e. after RESP returns to IDLE at cycle 4 and is re-sampled.
3. Starvation with STARVE_MAX=2: if_req and d_req held high, each port re-requesting after its gnt -> grant order D, D, I, D, D, I; starve_cnt clears on each I grant.
4. Write: d_req=1, d_wen=1, d_addr=0x5, d_wdata=0x1234 -> mem_en=1, mem_wen=1, mem_addr=0x5, mem_wdata=0x1234 in the grant cycle; d_rvalid pulse at T+2+MEM_LAT; d_rdata unchanged; if_rdata unchanged.
5. Reset mid-WAIT, MEM_LAT=3: assert rst_n=0 two cycles after grant -> all outputs 0 immediately, no rvalid. After release, a new if_req is served with the normal T+1 / T+5 timing.
6. MEM_LAT=3 read: mem_rdata valid only in cycle ISSUE+3 (other cycles driven 0xBAD) -> captured value is exactly the ISSUE+3 value; rvalid at T+5.
